// File: rtl/ucode_seq.sv
// Microcode sequencer: computes the next micro address for an external synchronous ROM
// from the sequencing field of the current control word, with stall, NMI/IRQ, halt and micro-stack.
module ucode_seq #(
  parameter int unsigned   CW        = 36,
  parameter int unsigned   UA        = 9,
  parameter int unsigned   FW        = 5,
  parameter int unsigned   SDEPTH    = 4,
  parameter int unsigned   WE_BIT    = 28,
  parameter logic [UA-1:0] RESET_VEC = 9'h1E0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rdy,
  input  logic [CW-1:0] ctl,
  input  logic [UA-2:0] opcode,
  input  logic          mode,
  input  logic          irq,
  input  logic          nmi,
  input  logic          I,
  output logic [UA-1:0] rom_addr,
  output logic          rom_en,
  output logic          sync,
  output logic          we,
  output logic          int_ack,
  output logic          int_nmi,
  output logic          stack_err
);

  localparam int unsigned NW = UA - 2;
  localparam int unsigned DW = $clog2(SDEPTH + 1);
  localparam int unsigned AW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  typedef enum logic [2:0] {
    SEQ_FETCH  = 3'b000,
    SEQ_NEXT   = 3'b001,
    SEQ_FINISH = 3'b010,
    SEQ_SAVE   = 3'b011,
    SEQ_CALL   = 3'b100,
    SEQ_RET    = 3'b101,
    SEQ_HALT   = 3'b110,
    SEQ_RSVD   = 3'b111
  } seq_t;

  seq_t          seq;
  logic [FW-1:0] fin;
  logic [NW-1:0] nxt;
  logic          ctl_unused;

  logic [UA-1:0] cur;
  logic [FW-1:0] finish;
  logic [DW-1:0] depth;
  logic          nmi_q;
  logic          nmi_pend;
  logic [UA-1:0] stack [SDEPTH];

  logic [UA-1:0] next_form;
  logic [UA-1:0] fetch_form;
  logic [AW-1:0] top;
  logic          take_vec;
  logic          vec_nmi;
  logic          push;
  logic          pop;
  logic          set_err;

  assign seq        = seq_t'(ctl[CW-1 -: 3]);
  assign fin        = ctl[CW-4 -: FW];
  assign nxt        = ctl[NW-1:0];
  assign ctl_unused = ^ctl;

  assign next_form  = {1'b1, mode, nxt};
  assign fetch_form = {1'b0, opcode};
  assign top        = AW'(depth - DW'(1));
  assign rom_en     = rdy | ~reset_n;
  assign sync       = (seq == SEQ_FETCH);

  // Next-address decode; a stalled or held sequencer simply re-issues cur.
  always_comb begin
    rom_addr = cur;
    take_vec = 1'b0;
    vec_nmi  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    set_err  = 1'b0;
    if (!reset_n) begin
      rom_addr = RESET_VEC;
    end else if (rdy) begin
      case (seq)
        SEQ_FETCH: begin
          if (nmi_pend) begin
            take_vec = 1'b1;
            vec_nmi  = 1'b1;
          end else if (irq && !I) begin
            take_vec = 1'b1;
          end else begin
            rom_addr = fetch_form;
          end
        end
        SEQ_FINISH: rom_addr = {1'b1, mode, 2'b10, finish};
        SEQ_CALL: begin
          rom_addr = next_form;
          if (depth == DW'(SDEPTH)) set_err = 1'b1;
          else                      push    = 1'b1;
        end
        SEQ_RET: begin
          if (depth == '0) begin
            rom_addr = fetch_form;
            set_err  = 1'b1;
          end else begin
            rom_addr = stack[top];
            pop      = 1'b1;
          end
        end
        SEQ_HALT: begin
          // Wake on any pending interrupt, but only vector if it is actually enabled.
          if (nmi_pend) begin
            take_vec = 1'b1;
            vec_nmi  = 1'b1;
          end else if (irq && !I) begin
            take_vec = 1'b1;
          end else if (irq) begin
            rom_addr = next_form;
          end
        end
        default: rom_addr = next_form;
      endcase
      if (take_vec) rom_addr = {1'b1, vec_nmi, 2'b11, {(UA-4){1'b0}}};
    end
  end

  // Sequencer state; only the NMI edge detector runs through a stall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur       <= RESET_VEC;
      finish    <= '0;
      depth     <= '0;
      nmi_q     <= 1'b0;
      nmi_pend  <= 1'b0;
      we        <= 1'b0;
      int_ack   <= 1'b0;
      int_nmi   <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (nmi && !nmi_q)          nmi_pend <= 1'b1;
      else if (take_vec && vec_nmi) nmi_pend <= 1'b0;
      if (rdy) begin
        cur     <= rom_addr;
        we      <= ctl[WE_BIT];
        int_ack <= take_vec;
        if (take_vec)         int_nmi   <= vec_nmi;
        if (seq == SEQ_SAVE)  finish    <= fin;
        if (push)             depth     <= depth + DW'(1);
        else if (pop)         depth     <= depth - DW'(1);
        if (set_err)          stack_err <= 1'b1;
      end else begin
        int_ack <= 1'b0;
      end
    end
  end

  // Return addresses wrap modulo the micro address space.
  always_ff @(posedge clk) begin
    if (push) stack[AW'(depth)] <= cur + UA'(1);
  end

endmodule

// File: tb/tb_ucode_seq.sv
// Bench for ucode_seq: synchronous ROM model, directed programs plus random programs,
// with a reference sequencer feeding a scoreboard that a separate monitor drains.
module tb_ucode_seq;

  localparam int SD = 2;

  logic        clk;
  logic        reset_n;
  logic        rdy;
  logic [35:0] ctl;
  logic [7:0]  opcode;
  logic        mode;
  logic        irq;
  logic        nmi;
  logic        i_flag;
  logic [8:0]  rom_addr;
  logic        rom_en;
  logic        sync;
  logic        we;
  logic        int_ack;
  logic        int_nmi;
  logic        stack_err;

  ucode_seq #(.SDEPTH(SD)) dut (
    .clk(clk), .reset_n(reset_n), .rdy(rdy), .ctl(ctl), .opcode(opcode), .mode(mode),
    .irq(irq), .nmi(nmi), .I(i_flag), .rom_addr(rom_addr), .rom_en(rom_en), .sync(sync),
    .we(we), .int_ack(int_ack), .int_nmi(int_nmi), .stack_err(stack_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [35:0] rom [512];

  always @(posedge clk) if (rom_en) ctl <= rom[rom_addr];

  typedef struct packed {
    logic [8:0] addr;
    logic       en;
    logic       sync;
    logic       we;
    logic       ack;
    logic       inmi;
    logic       err;
  } exp_t;

  exp_t exp_q [$];
  int   vectors   = 0;
  int   miscmp    = 0;

  // Reference model state
  int          m_cur;
  logic [35:0] m_ctl;
  bit          m_we, m_ack, m_inmi, m_err, m_pend, m_nmiq;
  int          m_fin;
  int          stk [$];

  function automatic logic [35:0] word(int sq, int fn, int nx);
    logic [35:0] r;
    r = 36'(sq) * 36'h2_0000_0000 + 36'(fn) * 36'h1000_0000 + 36'(nx);
    return r;
  endfunction

  // One clock of the reference sequencer: predicts this cycle's outputs, then advances.
  task automatic step();
    exp_t e;
    int   sq, a, vec, nform;
    sq    = int'(m_ctl[35:33]);
    nform = 256 + int'(mode) * 128 + int'(m_ctl[6:0]);
    vec   = -1;
    a     = m_cur;
    e.en  = rdy | ~reset_n;
    e.sync = (sq == 0);
    e.we  = m_we;
    e.ack = m_ack;
    e.inmi = m_inmi;
    e.err = m_err;
    if (!reset_n) begin
      a = 'h1E0;
    end else if (rdy) begin
      if (sq == 0) begin
        if (m_pend) vec = 1;
        else if (irq && !i_flag) vec = 0;
        else a = int'(opcode);
      end else if (sq == 2) begin
        a = 256 + int'(mode) * 128 + 64 + m_fin;
      end else if (sq == 4) begin
        a = nform;
        if (stk.size() == SD) m_err = 1;
        else stk.push_back((m_cur + 1) % 512);
      end else if (sq == 5) begin
        if (stk.size() == 0) begin
          a = int'(opcode);
          m_err = 1;
        end else a = stk.pop_back();
      end else if (sq == 6) begin
        if (m_pend) vec = 1;
        else if (irq && !i_flag) vec = 0;
        else if (irq) a = nform;
      end else begin
        a = nform;
      end
      if (vec >= 0) a = 256 + vec * 128 + 96;
    end
    e.addr = 9'(a);
    exp_q.push_back(e);
    if (!reset_n) begin
      m_cur = 'h1E0; m_we = 0; m_ack = 0; m_inmi = 0; m_err = 0;
      m_pend = 0; m_nmiq = 0; m_fin = 0;
      stk.delete();
      m_ctl = rom[9'h1E0];
    end else begin
      if (vec == 1) m_pend = 0;
      if (nmi && !m_nmiq) m_pend = 1;
      m_nmiq = nmi;
      if (rdy) begin
        m_cur = a;
        m_we  = m_ctl[28];
        m_ack = (vec >= 0);
        if (vec >= 0) m_inmi = (vec == 1);
        if (sq == 3) m_fin = int'(m_ctl[32:28]);
        m_ctl = rom[9'(a)];
      end else begin
        m_ack = 0;
      end
    end
  endtask

  function automatic bit cmp(string nm, logic [8:0] act, logic [8:0] exv);
    if (act !== exv) begin
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exv);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Monitor: compare DUT outputs against the queued prediction once per cycle.
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        bad = 1'b0;
        bad |= cmp("rom_addr",  rom_addr,          e.addr);
        bad |= cmp("rom_en",    9'(rom_en),        9'(e.en));
        bad |= cmp("sync",      9'(sync),          9'(e.sync));
        bad |= cmp("we",        9'(we),            9'(e.we));
        bad |= cmp("int_ack",   9'(int_ack),       9'(e.ack));
        bad |= cmp("int_nmi",   9'(int_nmi),       9'(e.inmi));
        bad |= cmp("stack_err", 9'(stack_err),     9'(e.err));
        vectors++;
        if (bad) miscmp++;
      end
    end
  end

  task automatic cyc();
    step();
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
  endtask

  task automatic clear_rom();
    for (int k = 0; k < 512; k++) rom[k] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; rdy = 1'b1; opcode = 8'hA9; mode = 1'b0;
    irq = 1'b0; nmi = 1'b0; i_flag = 1'b1;
    clear_rom();
    rom[9'h1E0] = word(1, 0, 'h05);
    rom[9'h0A9] = word(3, 3, 'h10);
    rom[9'h110] = word(2, 0, 0);
    rom[9'h185] = word(0, 0, 0);
    rom[9'h190] = word(2, 0, 0);
    @(posedge clk);
    m_cur = 'h1E0; m_we = 0; m_ack = 0; m_inmi = 0; m_err = 0;
    m_pend = 0; m_nmiq = 0; m_fin = 0; m_ctl = rom[9'h1E0];
    @(negedge clk);

    // Reset, NEXT, SAVE/FINISH in both pages
    cyc();
    reset_n = 1'b1;
    run(8);
    mode = 1'b1;
    do_reset();
    run(8);

    // NMI edge during stall, then held high
    clear_rom();
    mode = 1'b0; opcode = 8'h20;
    rom[9'h020] = word(1, 1, 'h60);
    do_reset();
    rdy = 1'b0; cyc();
    nmi = 1'b1; cyc();
    nmi = 1'b0; cyc();
    rdy = 1'b1; cyc();
    nmi = 1'b1; run(5);
    nmi = 1'b0; run(2);

    // Masked IRQ at FETCH and at HALT, then unmasked IRQ
    clear_rom();
    opcode = 8'h40;
    rom[9'h040] = word(6, 0, 'h15);
    rom[9'h160] = word(1, 0, 'h00);
    do_reset();
    irq = 1'b1; i_flag = 1'b1; cyc();
    irq = 1'b0; run(3);
    irq = 1'b1; cyc();
    i_flag = 1'b0; run(3);
    irq = 1'b0; i_flag = 1'b1;

    // Micro-stack overflow and underflow
    clear_rom();
    opcode = 8'h00;
    rom[9'h1E0] = word(4, 0, 'h10);
    rom[9'h110] = word(4, 1, 'h20);
    rom[9'h120] = word(4, 0, 'h30);
    rom[9'h130] = word(5, 0, 0);
    rom[9'h111] = word(5, 0, 0);
    rom[9'h1E1] = word(5, 0, 0);
    do_reset();
    run(9);

    // Return address wraps from 1FF to 000
    clear_rom();
    mode = 1'b1;
    rom[9'h1E0] = word(1, 0, 'h7F);
    rom[9'h1FF] = word(4, 0, 'h10);
    rom[9'h190] = word(5, 0, 0);
    do_reset();
    run(6);

    // Random programs and inputs
    for (int k = 0; k < 512; k++) rom[k] = {4'($urandom), $urandom};
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rdy    = ($urandom % 4) != 0;
      irq    = ($urandom % 8) == 0;
      i_flag = $urandom % 2;
      mode   = $urandom % 2;
      opcode = 8'($urandom);
      if ($urandom % 5 == 0) nmi = ~nmi;
      if ($urandom % 300 == 0) begin
        do_reset();
      end else begin
        cyc();
      end
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #5;
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
      miscmp++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
